// File: rtl/ray_pixel_streamer.sv
// Shades in-order pixel beats to RGB, buffers them in a FIFO and emits an AXI4-Stream video stream.
// Optional PIXEL_SHADE_EN: shade hit pixels from the surface point instead of flat white.
module ray_pixel_streamer #(
  parameter int          H_RES      = 8,
  parameter int          V_RES      = 8,
  parameter int          FIFO_DEPTH = 16,
  parameter int          AF_MARGIN  = 4,
  parameter logic [23:0] BG_COLOUR  = 24'h000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pixel_valid_in,
  input  logic [95:0] surface_point_in,
  input  logic        hit_in,
  output logic [23:0] out_tdata,
  output logic        out_tvalid,
  input  logic        out_tready,
  output logic        out_tuser,
  output logic        out_tlast,
  output logic        almost_full,
  output logic        overflow,
  output logic        frame_done
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [XW-1:0] X_LAST   = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_RES - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] MARGIN_C = CW'(AF_MARGIN);

  logic [23:0] hit_rgb;

`ifdef PIXEL_SHADE_EN
  // Magnitude of a Q8.24 value, saturated to 8 bits of fraction.
  function automatic logic [7:0] sat8(input logic [31:0] c);
    logic [31:0] mag;
    mag = c[31] ? (~c + 32'd1) : c;
    return (mag >= 32'h0100_0000) ? 8'hFF : mag[23:16];
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      assign hit_rgb[gi*8 +: 8] = sat8(surface_point_in[gi*32 +: 32]);
    end
  endgenerate
`else
  logic unused_surface_point;
  assign unused_surface_point = ^surface_point_in;
  assign hit_rgb = 24'hFFFFFF;
`endif

  logic          s1_valid_reg;
  logic [23:0]   s1_rgb_reg;
  logic [23:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [XW-1:0] x_reg, x_next, ld_x;
  logic [YW-1:0] y_reg, y_next, ld_y;
  logic          hs, load, full, push;

  always_comb begin
    hs     = out_tvalid & out_tready;
    load   = (~out_tvalid | out_tready) & (count_reg != '0);
    full   = (count_reg == DEPTH_C);
    // A full FIFO still accepts the write when the head is popped in the same cycle.
    push   = s1_valid_reg & (~full | load);
    x_next = (x_reg == X_LAST) ? '0 : x_reg + XW'(1);
    y_next = y_reg;
    if (x_reg == X_LAST) begin
      y_next = (y_reg == Y_LAST) ? '0 : y_reg + YW'(1);
    end
    // A load during a handshake holds the pixel after the one leaving now.
    ld_x = hs ? x_next : x_reg;
    ld_y = hs ? y_next : y_reg;
  end

  assign almost_full = ((DEPTH_C - count_reg) <= MARGIN_C);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_reg <= 1'b0;
      s1_rgb_reg   <= '0;
    end else begin
      s1_valid_reg <= pixel_valid_in;
      if (pixel_valid_in) begin
        s1_rgb_reg <= hit_in ? hit_rgb : BG_COLOUR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= s1_rgb_reg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (load) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(push) - CW'(load);
      if (s1_valid_reg & ~push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_tdata  <= '0;
      out_tvalid <= 1'b0;
      out_tuser  <= 1'b0;
      out_tlast  <= 1'b0;
      frame_done <= 1'b0;
      x_reg      <= '0;
      y_reg      <= '0;
    end else begin
      if (load) begin
        out_tdata  <= fifo_mem[rd_ptr_reg];
        out_tvalid <= 1'b1;
        out_tuser  <= (ld_x == '0) && (ld_y == '0);
        out_tlast  <= (ld_x == X_LAST);
      end else if (hs) begin
        out_tvalid <= 1'b0;
      end
      frame_done <= hs && (x_reg == X_LAST) && (y_reg == Y_LAST);
      if (hs) begin
        x_reg <= x_next;
        y_reg <= y_next;
      end
    end
  end

endmodule

// File: tb/tb_ray_pixel_streamer.sv
// Scoreboard bench for ray_pixel_streamer: driver queues expected beats, monitor checks the AXIS output.
module tb_ray_pixel_streamer;

  localparam int H = 8;
  localparam int V = 8;

  logic        clk;
  logic        rst;
  logic        pixel_valid_in;
  logic [95:0] surface_point_in;
  logic        hit_in;
  logic [23:0] out_tdata;
  logic        out_tvalid;
  logic        out_tready;
  logic        out_tuser;
  logic        out_tlast;
  logic        almost_full;
  logic        overflow;
  logic        frame_done;

  ray_pixel_streamer dut (
    .clk              (clk),
    .rst              (rst),
    .pixel_valid_in   (pixel_valid_in),
    .surface_point_in (surface_point_in),
    .hit_in           (hit_in),
    .out_tdata        (out_tdata),
    .out_tvalid       (out_tvalid),
    .out_tready       (out_tready),
    .out_tuser        (out_tuser),
    .out_tlast        (out_tlast),
    .almost_full      (almost_full),
    .overflow         (overflow),
    .frame_done       (frame_done)
  );

  typedef struct packed {
    logic [23:0] d;
    logic        u;
    logic        l;
    logic        fe;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          beat = 0;
  int          rx_count = 0;
  logic        ready_level = 1'b0;
  logic        rand_mode = 1'b0;
  logic [95:0] pts [4];
  logic [23:0] shd [4];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Sole driver of out_tready.
  initial begin
    out_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_tready = rand_mode ? 1'($urandom_range(0, 1)) : ready_level;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tvalid"}, 32'(out_tvalid), 0);
    chk({tag, "_tdata"}, 32'(out_tdata), 0);
    chk({tag, "_tuser"}, 32'(out_tuser), 0);
    chk({tag, "_tlast"}, 32'(out_tlast), 0);
    chk({tag, "_almost_full"}, 32'(almost_full), 0);
    chk({tag, "_overflow"}, 32'(overflow), 0);
    chk({tag, "_frame_done"}, 32'(frame_done), 0);
  endtask

  // Drive one pixel for one clock; optionally queue its expected beat.
  task automatic send(input logic hit, input int p, input logic keep);
    exp_t e;
    pixel_valid_in   = 1'b1;
    hit_in           = hit;
    surface_point_in = pts[p];
    if (keep) begin
      e.d  = hit ? shd[p] : 24'h000000;
      e.u  = (beat % (H * V)) == 0;
      e.l  = (beat % H) == H - 1;
      e.fe = (beat % (H * V)) == H * V - 1;
      sb.push_back(e);
      beat++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pixel_valid_in = 1'b0;
    hit_in         = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_tvalid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    sb.delete();
    beat = 0;
    @(negedge clk);
    chk_all_zero("rst");
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Monitor: pops on every handshake, checks frame_done and stall stability.
  logic        fd_exp = 1'b0;
  logic        stall = 1'b0;
  logic [25:0] held = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      fd_exp = 1'b0;
      stall  = 1'b0;
    end else begin
      chk("frame_done", 32'(frame_done), 32'(fd_exp));
      if (stall) begin
        chk("stall_tvalid", 32'(out_tvalid), 1);
        chk("stall_payload", 32'({out_tdata, out_tuser, out_tlast}), 32'(held));
      end
      fd_exp = 1'b0;
      if (out_tvalid && out_tready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got tdata %0h expected no beat", out_tdata);
        end else begin
          e = sb.pop_front();
          chk("tdata", 32'(out_tdata), 32'(e.d));
          chk("tuser", 32'(out_tuser), 32'(e.u));
          chk("tlast", 32'(out_tlast), 32'(e.l));
          fd_exp = e.fe;
          $display("beat %0d: tdata=%06h tuser=%0b tlast=%0b", rx_count, out_tdata, out_tuser, out_tlast);
          rx_count++;
        end
      end
      stall = out_tvalid && !out_tready;
      held  = {out_tdata, out_tuser, out_tlast};
    end
  end

  initial begin
    rst              = 1'b0;
    pixel_valid_in   = 1'b0;
    hit_in           = 1'b0;
    surface_point_in = '0;
    // {x,y,z} in Q8.24
    pts[0] = {32'h0080_0000, 32'hFFC0_0000, 32'h0300_0000};  // ( 0.5, -0.25, 3.0)
    pts[1] = {32'h0000_0000, 32'h0100_0000, 32'hFE80_0000};  // ( 0.0,  1.0, -1.5)
    pts[2] = {32'h0020_0000, 32'hFF80_0000, 32'h0010_0000};  // (0.125, -0.5, 0.0625)
    pts[3] = {32'hFF40_0000, 32'h0040_0000, 32'hFE00_0000};  // (-0.75, 0.25, -2.0)
`ifdef PIXEL_SHADE_EN
    shd[0] = 24'h8040FF;
    shd[1] = 24'h00FFFF;
    shd[2] = 24'h208010;
    shd[3] = 24'hC040FF;
`else
    for (int i = 0; i < 4; i++) shd[i] = 24'hFFFFFF;
`endif

    // Reset with random inputs.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      pixel_valid_in   = 1'($urandom_range(0, 1));
      hit_in           = 1'($urandom_range(0, 1));
      surface_point_in = {$urandom, $urandom, $urandom};
      ready_level      = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk_all_zero("reset");
    end
    idle();
    ready_level = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_tvalid", 32'(out_tvalid), 0);
    end

    // First-word latency and single hit / miss shading.
    @(posedge clk);
    #1;
    send(1'b1, 0, 1'b1);
    idle();
    @(negedge clk);
    chk("lat_n0_tvalid", 32'(out_tvalid), 0);
    @(negedge clk);
    chk("lat_n1_tvalid", 32'(out_tvalid), 0);
    @(negedge clk);
    chk("lat_n2_tvalid", 32'(out_tvalid), 1);
    @(posedge clk);
    #1;
    send(1'b0, 1, 1'b1);
    idle();
    wait_drain();
    do_reset();

    // Framing: one full frame back to back plus the first pixel of the next.
    for (int k = 0; k < 65; k++) send(1'((k % 5) != 3), k % 4, 1'b1);
    idle();
    wait_drain();

    // Random backpressure with sparse input.
    rand_mode = 1'b1;
    for (int k = 0; k < 24; k++) begin
      send(1'((k % 3) != 0), (k + 1) % 4, 1'b1);
      idle();
      repeat (3) @(posedge clk);
      #1;
    end
    rand_mode = 1'b0;
    wait_drain();

    // Overflow: output register plus 16 FIFO entries hold pixels 0..16.
    ready_level = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 20; k++) begin
      send(1'((k >= 17) || (k % 2 == 1)), k % 4, 1'(k < 17));
      @(negedge clk);
      chk($sformatf("almost_full_k%0d", k), 32'(almost_full), 32'(k >= 13));
      chk($sformatf("overflow_k%0d", k), 32'(overflow), 32'(k >= 18));
    end
    idle();
    ready_level = 1'b1;
    wait_drain();
    chk("overflow_sticky", 32'(overflow), 1);
    send(1'b0, 0, 1'b1);
    idle();
    wait_drain();

    // Mid-frame reset with pixels still in flight.
    for (int k = 0; k < 30; k++) send(1'b1, k % 4, 1'b1);
    idle();
    rst = 1'b0;
    sb.delete();
    beat = 0;
    @(negedge clk);
    chk_all_zero("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    send(1'b1, 2, 1'b1);
    idle();
    wait_drain();
    chk("post_reset_overflow", 32'(overflow), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
